// File: rtl/fft_pkg.sv
// fft_pkg: FSM encoding, rounding modes and width helpers
// shared by the FFT twiddle multiplier (fft_wm_seq).
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_F = 3'd1,
    MUL_R = 3'd2,
    MUL_I = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam int RND_TRUNC = 0;
  localparam int RND_CONV  = 1;

  function automatic int prod_w(input int dw, input int tw);
    return dw + tw + 2;
  endfunction

  function automatic int frac_w(input int tw);
    return tw - 1;
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat: scale one full-precision component by 2^-L, round,
// then wrap or (with FFT_WM_SAT_EN) clamp to DATA_WIDTH.
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH       = 25,
  parameter int TWIDDLE_WIDTH    = 10,
  parameter int ROUND_CONVERGENT = RND_CONV,
  localparam int PW = prod_w(DATA_WIDTH, TWIDDLE_WIDTH)
) (
  input  logic [PW-1:0]         p,
  output logic [DATA_WIDTH-1:0] z,
  output logic                  sat
);

  localparam int L  = frac_w(TWIDDLE_WIDTH);
  localparam int QW = PW - L;
  localparam logic [L-1:0] HALF = L'(1) << (L - 1);

  logic signed [QW-1:0] q;
  logic [L-1:0]         rem;
  logic                 inc;
  logic signed [QW:0]   r;

  assign q   = p[PW-1:L];
  assign rem = p[L-1:0];
  assign inc = (ROUND_CONVERGENT != RND_TRUNC) &&
               ((rem > HALF) || ((rem == HALF) && q[0]));
  assign r   = {q[QW-1], q} + {{QW{1'b0}}, inc};

`ifdef FFT_WM_SAT_EN
  localparam logic signed [QW:0] ZMAX =
    {{(QW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [QW:0] ZMIN = ~ZMAX;

  always_comb begin
    z   = r[DATA_WIDTH-1:0];
    sat = 1'b0;
    if (r > ZMAX) begin
      z   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat = 1'b1;
    end else if (r < ZMIN) begin
      z   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^r[QW:DATA_WIDTH];
  assign z   = r[DATA_WIDTH-1:0];
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/fft_wm_seq.sv
// fft_wm_seq: z = x*w (or x*conj(w)) on one shared multiplier, Karatsuba
// 3-multiply schedule, valid/ready both sides. Option: FFT_WM_SAT_EN.
module fft_wm_seq
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH       = 25,
  parameter int TWIDDLE_WIDTH    = 10,
  parameter int NLOG2            = 10,
  parameter int ROUND_CONVERGENT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     conj_i,
  input  logic [NLOG2-1:0]         ctr_i,
  input  logic [DATA_WIDTH-1:0]    x_re_i,
  input  logic [DATA_WIDTH-1:0]    x_im_i,
  input  logic [TWIDDLE_WIDTH-1:0] w_re_i,
  input  logic [TWIDDLE_WIDTH-1:0] w_im_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NLOG2-1:0]         ctr_o,
  output logic [DATA_WIDTH-1:0]    z_re_o,
  output logic [DATA_WIDTH-1:0]    z_im_o,
  output logic                     ovf_o
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = TWIDDLE_WIDTH;
  localparam int PW = prod_w(DW, TW);
  localparam int MW = PW + 1;

  state_e state_q, state_d;

  logic signed [DW-1:0] a_q, b_q;
  logic signed [TW-1:0] c_q;
  logic signed [TW:0]   d_q;
  logic [NLOG2-1:0]     tag_q;
  logic signed [PW-1:0] f_q, r_q;

  logic signed [DW:0]   mx;
  logic signed [TW+1:0] my;
  logic signed [MW-1:0] prod;
  logic signed [PW-1:0] p, i_p;
  logic                 accept;
  logic                 unused_msb;

  logic [DW-1:0]    zr_d, zi_d;
  logic             sat_re, sat_im;
  logic [DW-1:0]    z_re_q, z_im_q;
  logic [NLOG2-1:0] ctr_q;

  assign in_ready_o  = (state_q == IDLE) ||
                       ((state_q == HOLD) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == HOLD);
  assign z_re_o      = z_re_q;
  assign z_im_o      = z_im_q;
  assign ctr_o       = ctr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_d = MUL_F;
      MUL_F:   state_d = MUL_R;
      MUL_R:   state_d = MUL_I;
      MUL_I:   state_d = HOLD;
      HOLD:    if (out_ready_i) state_d = in_valid_i ? MUL_F : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // f = c(a-b); R = b(c-d)+f; I = a(c+d)-f
  always_comb begin
    mx = '0;
    my = '0;
    unique case (1'b1)
      (state_q == MUL_F): begin
        mx = {a_q[DW-1], a_q} - {b_q[DW-1], b_q};
        my = {{2{c_q[TW-1]}}, c_q};
      end
      (state_q == MUL_R): begin
        mx = {b_q[DW-1], b_q};
        my = {{2{c_q[TW-1]}}, c_q} - {d_q[TW], d_q};
      end
      (state_q == MUL_I): begin
        mx = {a_q[DW-1], a_q};
        my = {{2{c_q[TW-1]}}, c_q} + {d_q[TW], d_q};
      end
      default: ;
    endcase
  end

  assign prod       = mx * my;
  assign p          = prod[PW-1:0];
  assign unused_msb = prod[MW-1];
  assign i_p        = p - f_q;

  fft_round_sat #(
    .DATA_WIDTH       (DW),
    .TWIDDLE_WIDTH    (TW),
    .ROUND_CONVERGENT (ROUND_CONVERGENT)
  ) u_rnd_re (
    .p   (r_q),
    .z   (zr_d),
    .sat (sat_re)
  );

  fft_round_sat #(
    .DATA_WIDTH       (DW),
    .TWIDDLE_WIDTH    (TW),
    .ROUND_CONVERGENT (ROUND_CONVERGENT)
  ) u_rnd_im (
    .p   (i_p),
    .z   (zi_d),
    .sat (sat_im)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      tag_q  <= '0;
      f_q    <= '0;
      r_q    <= '0;
      z_re_q <= '0;
      z_im_q <= '0;
      ctr_q  <= '0;
    end else begin
      if (accept) begin
        a_q   <= x_re_i;
        b_q   <= x_im_i;
        c_q   <= w_re_i;
        // one extra bit so negating the most negative twiddle cannot wrap
        d_q   <= conj_i ? -{w_im_i[TW-1], w_im_i}
                        :  {w_im_i[TW-1], w_im_i};
        tag_q <= ctr_i;
      end
      if (state_q == MUL_F) f_q <= p;
      if (state_q == MUL_R) r_q <= p + f_q;
      if (state_q == MUL_I) begin
        z_re_q <= zr_d;
        z_im_q <= zi_d;
        ctr_q  <= tag_q;
      end
    end
  end

`ifdef FFT_WM_SAT_EN
  logic ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else if (state_q == MUL_I && (sat_re || sat_im)) ovf_q <= 1'b1;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_sat;
  assign unused_sat = sat_re | sat_im;
  assign ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_wm_seq.sv
// tb_fft_wm_seq: directed + random checks of fft_wm_seq against a
// direct complex-multiply reference with explicit rounding/wrap rules.
module tb_fft_wm_seq;

  localparam int DW = 25;
  localparam int TW = 10;
  localparam int NL = 10;
  localparam int RC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, conj;
  logic [NL-1:0] ctr_in, ctr_out;
  logic [DW-1:0] x_re, x_im, z_re, z_im;
  logic [TW-1:0] w_re, w_im;
  logic          out_valid, out_ready, ovf;

  int  n_chk = 0;
  int  n_err = 0;
  bit  ovf_m = 1'b0;

  always #5 clk = ~clk;

  fft_wm_seq #(
    .DATA_WIDTH       (DW),
    .TWIDDLE_WIDTH    (TW),
    .NLOG2            (NL),
    .ROUND_CONVERGENT (RC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .conj_i      (conj),
    .ctr_i       (ctr_in),
    .x_re_i      (x_re),
    .x_im_i      (x_im),
    .w_re_i      (w_re),
    .w_im_i      (w_im),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ctr_o       (ctr_out),
    .z_re_o      (z_re),
    .z_im_o      (z_im),
    .ovf_o       (ovf)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint scale(input longint p);
    longint q, rem;
    q   = p >>> (TW - 1);
    rem = p - (q <<< (TW - 1));
    if (RC == 1 && (rem > (64'sd1 <<< (TW - 2)) ||
        (rem == (64'sd1 <<< (TW - 2)) && q[0])))
      q = q + 1;
    return q;
  endfunction

  task automatic fit(input longint v, output longint r);
    longint hi, lo;
    hi = (64'sd1 <<< (DW - 1)) - 1;
    lo = -(64'sd1 <<< (DW - 1));
`ifdef FFT_WM_SAT_EN
    r = v;
    if (v > hi) begin r = hi; ovf_m = 1'b1; end
    if (v < lo) begin r = lo; ovf_m = 1'b1; end
`else
    r = v & ((64'sd1 <<< DW) - 1);
    if (r > hi) r = r - (64'sd1 <<< DW);
`endif
  endtask

  task automatic model(input longint a, b, c, wi, input bit cj,
                       output longint zr, zi);
    longint d;
    d = cj ? -wi : wi;
    fit(scale(a * c - b * d), zr);
    fit(scale(a * d + b * c), zi);
  endtask

  task automatic drive(input longint a, b, c, wi, input bit cj,
                       input logic [NL-1:0] tag);
    x_re   = a[DW-1:0];
    x_im   = b[DW-1:0];
    w_re   = c[TW-1:0];
    w_im   = wi[TW-1:0];
    conj   = cj;
    ctr_in = tag;
  endtask

  task automatic send(input longint a, b, c, wi, input bit cj,
                      input logic [NL-1:0] tag);
    longint er, ei;
    int lat;
    model(a, b, c, wi, cj, er, ei);
    @(negedge clk);
    drive(a, b, c, wi, cj, tag);
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    chk("z_re", longint'($signed(z_re)), er);
    chk("z_im", longint'($signed(z_im)), ei);
    chk("ctr_o", ctr_out, tag);
    chk("ovf", ovf, ovf_m);
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic signed [DW-1:0] ra, rb;
    logic signed [TW-1:0] rc, rw;
    logic [31:0]          u0, u1, u2, u3, u4;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 1'b0, '0);
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_z_re", z_re, 0);
    chk("rst_z_im", z_im, 0);
    chk("rst_ctr", ctr_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;

    send(1000, 0, 256, 0, 1'b0, 10'd77);
    send(0, 1000, 0, 256, 1'b0, 10'd1);
    send(0, 1000, 0, 256, 1'b1, 10'd2);
    send(1, 0, 256, 0, 1'b0, 10'd3);
    send(3, 0, 256, 0, 1'b0, 10'd4);
    send(-1, 0, 256, 0, 1'b0, 10'd5);
    send(-(64'sd1 <<< 24), -(64'sd1 <<< 24), -512, -512, 1'b0, 10'd6);
    send(7, -9, 100, -200, 1'b1, 10'd7);

    for (int k = 0; k < 40; k++) begin
      u0 = $urandom; u1 = $urandom; u2 = $urandom;
      u3 = $urandom; u4 = $urandom;
      ra = u0[DW-1:0];
      rb = u1[DW-1:0];
      rc = u2[TW-1:0];
      rw = u3[TW-1:0];
      if (k < 20) begin
        ra = ra >>> 3;
        rb = rb >>> 3;
      end
      send(ra, rb, rc, rw, u4[NL], u4[NL-1:0]);
    end

    begin : backpressure
      longint  sa[4], sb[4], sc[4], sw[4], er[4], ei[4];
      bit      scj[4];
      logic [NL-1:0] st[4];
      int      t_out[4];
      int      idx_in, idx_out, stall;
      bit      seen;
      idx_in = 0; idx_out = 0; stall = 0; seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        u0 = $urandom; u1 = $urandom; u2 = $urandom;
        ra = u0[DW-1:0];
        rb = u1[DW-1:0];
        rc = u2[TW-1:0];
        rw = u2[2*TW-1:TW];
        sa[k] = ra >>> 2; sb[k] = rb >>> 2; sc[k] = rc; sw[k] = rw;
        scj[k] = u2[31];
        st[k]  = u2[29:20];
        t_out[k] = 0;
        model(sa[k], sb[k], sc[k], sw[k], scj[k], er[k], ei[k]);
      end
      for (int cyc = 0; cyc < 200 && idx_out < 4; cyc++) begin
        @(negedge clk);
        if (out_valid) begin
          if (!seen) begin
            seen  = 1'b1;
            stall = 10;
          end
          out_ready = (stall == 0);
          if (stall > 0) stall--;
        end else begin
          out_ready = 1'b0;
        end
        in_valid = (idx_in < 4);
        if (idx_in < 4)
          drive(sa[idx_in], sb[idx_in], sc[idx_in], sw[idx_in],
                scj[idx_in], st[idx_in]);
        #1;
        if (out_valid) begin
          chk("bp_z_re", longint'($signed(z_re)), er[idx_out]);
          chk("bp_z_im", longint'($signed(z_im)), ei[idx_out]);
          chk("bp_ctr", ctr_out, st[idx_out]);
          if (!out_ready) begin
            chk("bp_stall_ready", in_ready, 0);
          end else begin
            t_out[idx_out] = cyc;
            idx_out++;
          end
        end
        if (in_valid && in_ready) idx_in++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("bp_count", idx_out, 4);
      for (int k = 1; k < 4; k++)
        chk("bp_spacing", t_out[k] - t_out[k-1], 4);
    end

    send(1000, 0, 256, 0, 1'b0, 10'd9);
    @(negedge clk);
    drive(1000, 0, 256, 0, 1'b0, 10'd10);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    ovf_m = 1'b0;
    chk("arst_valid", out_valid, 0);
    chk("arst_z_re", z_re, 0);
    chk("arst_z_im", z_im, 0);
    chk("arst_ctr", ctr_out, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("arst_no_stale", out_valid, 0);
    end
    send(-3000, 1500, 300, -100, 1'b1, 10'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
